csi2hdmi_bridge: RTL and testbench

Parametrised camera-to-HDMI crossing with line-count-based start-up sequencing. Sits between the RGB/debayer output (camera clock `clk`) and the HDMI timing generator (`clk_pix`). It contains a built-in gray-pointer async FIFO acting as the line buffer, synchronised per-frame flushing, and sticky overflow/underflow flags. Pixel width, buffer depth and the line thresholds are parameters.

---
 rtl/csi2hdmi_bridge_pkg.sv | 18 +
 rtl/csi2hdmi_bridge_afifo.sv | 139 +++++++++++++
 rtl/csi2hdmi_bridge.sv | 149 ++++++++++++++
 tb/tb_csi2hdmi_bridge.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csi2hdmi_bridge_pkg.sv
// Shared types, line-state encoding and default sizing constants for the
// CSI-to-HDMI bridge.
package hdmi_pkg;
    localparam int PIX_BITS            = 24;
    localparam int CSI_SKIP_LINES      = 3;
    localparam int CSI_MAX_LINES       = 1300;
    localparam int LBUF_DEPTH_LOG2     = 12;
    localparam int HDMI_START_LINE_DEF = 1;

    typedef logic [PIX_BITS-1:0] pix_t;
    typedef logic [10:0]         bus11_t;

    typedef enum logic [1:0] {
        LS_IDLE  = 2'd0,
        LS_COUNT = 2'd1,
        LS_SAT   = 2'd2
    } line_state_t;
endpackage

// File: rtl/csi2hdmi_bridge_afifo.sv
// Dual-clock line buffer: RAM, gray-coded pointers with 2-FF crossings,
// conservative full/empty, write-side level and sticky error flags.
module csi_afifo #(
    parameter int PIX_W      = 24,
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                  wclk,
    input  logic                  wrst,
    input  logic                  wflush,
    input  logic                  wr_en,
    input  logic [PIX_W-1:0]      wdata,
    output logic                  overflow,
    output logic [DEPTH_LOG2:0]   wr_level,
    input  logic                  rclk,
    input  logic                  rflush,
    input  logic                  rd_en,
    output logic [PIX_W-1:0]      rdata,
    output logic                  underflow
);
    localparam int PW = DEPTH_LOG2 + 1;
    typedef logic [PW-1:0] ptr_t;
    localparam ptr_t DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b = g;
        for (int i = 1; i < PW; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

    logic [PIX_W-1:0] mem_q [2**DEPTH_LOG2];

    ptr_t wbin_q, wbin_d, wgray_q, rgray_s1_q, rgray_s2_q, rbin_sync_s, used_s, level_q;
    ptr_t rbin_q, rbin_d, rgray_q, wgray_s1_q, wgray_s2_q, wbin_sync_s;
    logic full_s, wr_do_s, empty_s, rd_do_s;
    logic overflow_q, underflow_q;
    logic [PIX_W-1:0] rdata_q;

    // Occupancy beyond DEPTH only appears transiently around a flush; treat it as full.
    assign rbin_sync_s = gray2bin(rgray_s2_q);
    assign used_s      = wbin_q - rbin_sync_s;
    assign full_s      = (used_s >= DEPTH);
    assign wr_do_s     = wr_en & ~full_s & ~wflush;

    // Write pointer next state.
    always_comb begin
        wbin_d = wbin_q;
        if (wflush) begin
            wbin_d = '0;
        end else if (wr_do_s) begin
            wbin_d = wbin_q + ptr_t'(1);
        end else begin
            wbin_d = wbin_q;
        end
    end

    // Write-side pointer, level and overflow flag.
    always_ff @(posedge wclk) begin
        if (wflush) begin
            wbin_q     <= '0;
            wgray_q    <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wbin_q     <= wbin_d;
            wgray_q    <= bin2gray(wbin_d);
            level_q    <= wbin_d - rbin_sync_s;
            overflow_q <= overflow_q | (wr_en & full_s);
        end
    end

    // RAM write port.
    always_ff @(posedge wclk) begin
        if (wr_do_s) begin
            mem_q[wbin_q[DEPTH_LOG2-1:0]] <= wdata;
        end
    end

    // Read pointer crossing into the write domain.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            rgray_s1_q <= '0;
            rgray_s2_q <= '0;
        end else begin
            rgray_s1_q <= rgray_q;
            rgray_s2_q <= rgray_s1_q;
        end
    end

    assign wbin_sync_s = gray2bin(wgray_s2_q);
    assign empty_s     = (rbin_q == wbin_sync_s);
    assign rd_do_s     = rd_en & ~empty_s;

    // Read pointer next state.
    always_comb begin
        rbin_d = rbin_q;
        if (rd_do_s) begin
            rbin_d = rbin_q + ptr_t'(1);
        end else begin
            rbin_d = rbin_q;
        end
    end

    // Read side: pointer, write-pointer crossing, output pixel and underflow.
    always_ff @(posedge rclk) begin
        if (rflush) begin
            rbin_q      <= '0;
            rgray_q     <= '0;
            wgray_s1_q  <= '0;
            wgray_s2_q  <= '0;
            rdata_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            wgray_s1_q <= wgray_q;
            wgray_s2_q <= wgray_s1_q;
            rbin_q     <= rbin_d;
            rgray_q    <= bin2gray(rbin_d);
            if (rd_do_s) begin
                rdata_q <= mem_q[rbin_q[DEPTH_LOG2-1:0]];
            end else if (rd_en) begin
                rdata_q     <= '0;
                underflow_q <= 1'b1;
            end else begin
                rdata_q <= rdata_q;
            end
        end
    end

    assign overflow  = overflow_q;
    assign wr_level  = level_q;
    assign rdata     = rdata_q;
    assign underflow = underflow_q;
endmodule

// File: rtl/csi2hdmi_bridge.sv
// Camera-to-HDMI crossing: CSI line counter with start-up sequencing,
// per-frame flush generation and the dual-clock line buffer.
module csi2hdmi_bridge
    import hdmi_pkg::*;
#(
    parameter int PIX_W           = $bits(pix_t),
    parameter int DEPTH_LOG2      = LBUF_DEPTH_LOG2,
    parameter int LINE_W          = $bits(bus11_t),
    parameter int SKIP_LINES      = CSI_SKIP_LINES,
    parameter int HDMI_START_LINE = HDMI_START_LINE_DEF,
    parameter int MAX_LINES       = CSI_MAX_LINES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_pix,
    input  logic                  csi_in_frame,
    input  logic                  csi_in_line,
    input  logic [PIX_W-1:0]      rgb_pix,
    input  logic                  rgb_reading,
    output logic                  rgb_valid,
    output logic [LINE_W-1:0]     line_count,
    output logic                  overflow,
    output logic [DEPTH_LOG2:0]   wr_level,
    input  logic                  hdmi_frame,
    input  logic                  hdmi_blank,
    output logic                  hdmi_reset_n,
    output logic [PIX_W-1:0]      hdmi_pix,
    output logic                  underflow
);
    localparam logic [LINE_W-1:0] MAX_CNT = LINE_W'(MAX_LINES);

    line_state_t       state_q, state_d;
    logic [LINE_W-1:0] count_q, count_d;
    logic              line_s_q, line_prev_q, line_rise_s;
    logic              rgb_valid_q, hdmi_rst_n_q;
    logic              hframe_s1_q, hframe_s2_q;
    logic              flush_w_s, flush_r_s1_q, flush_r_s2_q;

    // Line strobe capture and delayed copy; the count moves two cycles after a rise.
    always_ff @(posedge clk) begin
        if (reset) begin
            line_s_q    <= 1'b0;
            line_prev_q <= 1'b0;
        end else begin
            line_s_q    <= csi_in_line;
            line_prev_q <= line_s_q;
        end
    end

    assign line_rise_s = line_s_q & ~line_prev_q;

    // Line FSM state and count registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LS_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Dropping the frame wins over any line edge seen in the same cycle.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (!csi_in_frame) begin
            state_d = LS_IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                LS_IDLE: begin
                    state_d = LS_COUNT;
                    count_d = line_rise_s ? LINE_W'(1) : '0;
                end
                LS_COUNT: begin
                    if (count_q >= MAX_CNT) begin
                        state_d = LS_SAT;
                    end else if (line_rise_s) begin
                        count_d = count_q + LINE_W'(1);
                        state_d = (count_q == MAX_CNT - LINE_W'(1)) ? LS_SAT : LS_COUNT;
                    end else begin
                        state_d = LS_COUNT;
                    end
                end
                LS_SAT: begin
                    state_d = LS_SAT;
                    count_d = MAX_CNT;
                end
                default: begin
                    state_d = LS_IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    // Start-up enables derived from the line count.
    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_valid_q  <= 1'b0;
            hdmi_rst_n_q <= 1'b0;
        end else begin
            rgb_valid_q  <= (count_q >= LINE_W'(SKIP_LINES));
            hdmi_rst_n_q <= (count_q >= LINE_W'(HDMI_START_LINE));
        end
    end

    // HDMI frame flag into the camera clock.
    always_ff @(posedge clk) begin
        if (reset) begin
            hframe_s1_q <= 1'b0;
            hframe_s2_q <= 1'b0;
        end else begin
            hframe_s1_q <= hdmi_frame;
            hframe_s2_q <= hframe_s1_q;
        end
    end

    assign flush_w_s = reset | (~csi_in_frame & ~hframe_s2_q);

    // Flush request into the pixel clock; this path is itself the read-side reset.
    always_ff @(posedge clk_pix) begin
        flush_r_s1_q <= flush_w_s;
        flush_r_s2_q <= flush_r_s1_q;
    end

    csi_afifo #(
        .PIX_W      (PIX_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_lbuf (
        .wclk      (clk),
        .wrst      (reset),
        .wflush    (flush_w_s),
        .wr_en     (rgb_reading),
        .wdata     (rgb_pix),
        .overflow  (overflow),
        .wr_level  (wr_level),
        .rclk      (clk_pix),
        .rflush    (flush_r_s2_q),
        .rd_en     (~hdmi_blank),
        .rdata     (hdmi_pix),
        .underflow (underflow)
    );

    assign line_count   = count_q;
    assign rgb_valid    = rgb_valid_q;
    assign hdmi_reset_n = hdmi_rst_n_q;
endmodule

// File: tb/tb_csi2hdmi_bridge.sv
// Self-checking bench for csi2hdmi_bridge: line-count table, hand-written
// start-up sequences and randomized FIFO traffic against a queue model.
`timescale 1ns/1ps
module tb_csi2hdmi_bridge;
    logic        clk = 1'b0;
    logic        clk_pix = 1'b0;
    logic        reset = 1'b1;
    logic        csi_in_frame = 1'b0;
    logic        csi_in_line = 1'b0;
    logic [23:0] rgb_pix = 24'h0;
    logic        rgb_reading = 1'b0;
    logic        rgb_valid;
    logic [10:0] line_count;
    logic        overflow;
    logic [12:0] wr_level;
    logic        hdmi_frame = 1'b0;
    logic        hdmi_blank = 1'b1;
    logic        hdmi_reset_n;
    logic [23:0] hdmi_pix;
    logic        underflow;

    always #2.5 clk = ~clk;
    always #6.734 clk_pix = ~clk_pix;

    csi2hdmi_bridge dut (
        .clk          (clk),
        .reset        (reset),
        .clk_pix      (clk_pix),
        .csi_in_frame (csi_in_frame),
        .csi_in_line  (csi_in_line),
        .rgb_pix      (rgb_pix),
        .rgb_reading  (rgb_reading),
        .rgb_valid    (rgb_valid),
        .line_count   (line_count),
        .overflow     (overflow),
        .wr_level     (wr_level),
        .hdmi_frame   (hdmi_frame),
        .hdmi_blank   (hdmi_blank),
        .hdmi_reset_n (hdmi_reset_n),
        .hdmi_pix     (hdmi_pix),
        .underflow    (underflow)
    );

    localparam int CAP      = 4096;
    localparam int MAXL     = 1300;
    localparam int SKIPL    = 3;
    localparam int STARTL   = 1;

    int errs = 0;
    int checks = 0;

    // Reference model of the line buffer contents and flags
    logic [23:0] model_q[$];
    logic [23:0] exp_pix = 24'h0;
    logic        exp_unf = 1'b0;
    logic        exp_ovf = 1'b0;

    typedef struct {
        int nlines;
        int exp_count;
        bit exp_valid;
        bit exp_hrst;
    } line_vec_t;
    line_vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic line_pulse();
        csi_in_line = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        csi_in_line = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int n);
        csi_in_frame = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("idle_count", line_count, 0);
        csi_in_frame = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < n; i++) line_pulse();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [23:0] v);
        rgb_pix = v;
        rgb_reading = 1'b1;
        @(posedge clk);
        #1;
        rgb_reading = 1'b0;
        if (model_q.size() < CAP) model_q.push_back(v);
        else exp_ovf = 1'b1;
    endtask

    task automatic rd(input int n, input bit stall);
        logic [23:0] got;
        @(posedge clk_pix);
        #1;
        for (int i = 0; i < n; i++) begin
            if (stall && $urandom_range(0, 3) == 0) begin
                hdmi_blank = 1'b1;
                @(posedge clk_pix);
                #1;
                check("blank_hold", hdmi_pix, exp_pix);
            end
            hdmi_blank = 1'b0;
            @(posedge clk_pix);
            #1;
            if (model_q.size() > 0) begin
                got = model_q.pop_front();
                exp_pix = got;
            end else begin
                exp_pix = 24'h0;
                exp_unf = 1'b1;
            end
            check("rd_pix", hdmi_pix, exp_pix);
        end
        hdmi_blank = 1'b1;
        check("underflow", underflow, exp_unf);
    endtask

    task automatic flush_chk();
        @(posedge clk);
        #1;
        csi_in_frame = 1'b0;
        hdmi_frame = 1'b0;
        hdmi_blank = 1'b1;
        repeat (8) @(posedge clk_pix);
        #1;
        check("flush_level", wr_level, 0);
        check("flush_ovf", overflow, 0);
        check("flush_pix", hdmi_pix, 0);
        check("flush_unf", underflow, 0);
        model_q.delete();
        exp_pix = 24'h0;
        exp_unf = 1'b0;
        exp_ovf = 1'b0;
        csi_in_frame = 1'b1;
        hdmi_frame = 1'b1;
        repeat (4) @(posedge clk_pix);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int ec;

        vecs[0] = '{0, 0, 1'b0, 1'b0};
        vecs[1] = '{1, 1, 1'b0, 1'b1};
        vecs[2] = '{2, 2, 1'b0, 1'b1};
        vecs[3] = '{3, 3, 1'b1, 1'b1};
        vecs[4] = '{7, 7, 1'b1, 1'b1};
        vecs[5] = '{1400, 1300, 1'b1, 1'b1};

        // Reset state
        repeat (10) @(posedge clk_pix);
        @(posedge clk);
        #1;
        check("rst_valid", rgb_valid, 0);
        check("rst_hrst", hdmi_reset_n, 0);
        check("rst_count", line_count, 0);
        check("rst_ovf", overflow, 0);
        check("rst_level", wr_level, 0);
        check("rst_pix", hdmi_pix, 0);
        check("rst_unf", underflow, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Start-up sequencing with exact cycle positions
        csi_in_frame = 1'b1;
        @(posedge clk);
        #1;
        csi_in_line = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("cnt_edge1", line_count, 1);
        check("hrst_early", hdmi_reset_n, 0);
        @(posedge clk);
        #1;
        check("hrst_rise", hdmi_reset_n, 1);
        csi_in_line = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        line_pulse();
        csi_in_line = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("cnt_line3", line_count, 3);
        check("valid_early", rgb_valid, 0);
        @(posedge clk);
        #1;
        check("valid_rise", rgb_valid, 1);
        csi_in_line = 1'b0;
        @(posedge clk);
        #1;
        line_pulse();
        line_pulse();
        repeat (2) @(posedge clk);
        #1;
        check("cnt_5", line_count, 5);

        // Frame drop coinciding with a line edge
        csi_in_line = 1'b1;
        @(posedge clk);
        #1;
        csi_in_frame = 1'b0;
        @(posedge clk);
        #1;
        check("drop_priority", line_count, 0);
        csi_in_line = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset in the middle of a line
        csi_in_frame = 1'b1;
        @(posedge clk);
        #1;
        line_pulse();
        line_pulse();
        check("cnt_pre_rst", line_count, 2);
        csi_in_line = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        csi_in_line = 1'b0;
        @(posedge clk);
        #1;
        check("midline_rst_cnt", line_count, 0);
        check("midline_rst_hrst", hdmi_reset_n, 0);
        reset = 1'b0;
        csi_in_frame = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Table-driven frames
        for (int v = 0; v < 6; v++) begin
            run_frame(vecs[v].nlines);
            check("tbl_count", line_count, vecs[v].exp_count);
            check("tbl_valid", rgb_valid, vecs[v].exp_valid);
            check("tbl_hrst", hdmi_reset_n, vecs[v].exp_hrst);
        end

        // Random frames against the counting rule
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(0, 12);
            ec = (n > MAXL) ? MAXL : n;
            run_frame(n);
            check("rnd_count", line_count, ec);
            check("rnd_valid", rgb_valid, (ec >= SKIPL) ? 1 : 0);
            check("rnd_hrst", hdmi_reset_n, (ec >= STARTL) ? 1 : 0);
        end

        // Ordered 100-pixel transfer
        flush_chk();
        for (int i = 1; i <= 100; i++) wr(24'(i));
        repeat (3) @(posedge clk);
        #1;
        check("lvl_100", wr_level, 100);
        repeat (4) @(posedge clk_pix);
        rd(100, 1'b0);

        // Reset clears the read side within three pixel-clock edges
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (3) @(posedge clk_pix);
        #1;
        check("pix_after_rst", hdmi_pix, 0);
        check("unf_after_rst", underflow, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        flush_chk();

        // Randomized rounds, each ending with a read from empty and a flush
        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(1, 300);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 2) == 0) begin
                    @(posedge clk);
                    #1;
                end
                wr(24'($urandom));
            end
            repeat (3) @(posedge clk);
            #1;
            check("rnd_level", wr_level, n);
            repeat (4) @(posedge clk_pix);
            rd(n + 1, 1'b1);
            flush_chk();
        end

        // Fill past capacity with reads stalled
        for (int i = 0; i <= CAP; i++) wr(24'(i + 1));
        repeat (3) @(posedge clk);
        #1;
        check("full_level", wr_level, CAP);
        check("full_ovf", overflow, exp_ovf);
        repeat (4) @(posedge clk_pix);
        rd(CAP, 1'b0);
        rd(1, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check("drained_level", wr_level, 0);
        flush_chk();

        // Flush in the middle of a transfer
        for (int i = 0; i < 50; i++) wr(24'hA00000 + 24'(i));
        repeat (4) @(posedge clk_pix);
        rd(10, 1'b0);
        flush_chk();
        for (int i = 0; i < 5; i++) wr(24'hB00000 + 24'(i));
        repeat (3) @(posedge clk);
        #1;
        check("refill_level", wr_level, 5);
        repeat (4) @(posedge clk_pix);
        rd(5, 1'b0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
